sim_target_sched: RTL and testbench

//  Schedules up to NSLOT simulated targets onto the single sim_target datapath.

---
 rtl/sim_target_sched.sv | 219 +++++++++++++++++++++
 tb/tb_sim_target_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_target_sched.sv
// Time-shares the sim_target datapath among NSLOT target slots using shadow/active parameter banks.
// Optional SIM_SCHED_RR_EN: round-robin scan start; otherwise fixed priority from slot 0.
module sim_target_sched #(
    parameter int NSLOT   = 4,
    parameter int BEAR_W  = 12,
    parameter int RANGE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    output logic               wr_rdy_o,
    input  logic [2:0]         wr_slot_i,
    input  logic [1:0]         wr_addr_i,
    input  logic [15:0]        wr_data_i,
    input  logic               commit_i,
    output logic               commit_pend_o,
    input  logic [BEAR_W-1:0]  bear_i,
    input  logic [RANGE_W-1:0] range_i,
    output logic [BEAR_W-1:0]  start_angle_o,
    output logic [BEAR_W-1:0]  end_angle_o,
    output logic [RANGE_W-1:0] start_range_o,
    output logic [2:0]         angle_mode_o,
    output logic [2:0]         range_mode_o,
    output logic               slot_valid_o,
    output logic [2:0]         cur_slot_o,
    output logic [15:0]        rev_cnt_o
);
    localparam int SW = (NSLOT > 2) ? $clog2(NSLOT) : 1;
    localparam logic [SW:0] NS = (SW+1)'(NSLOT);
    localparam logic [SW-1:0] LAST = SW'(NSLOT - 1);
    localparam logic [BEAR_W-1:0] HALF = BEAR_W'(1) << (BEAR_W - 1);

    typedef enum logic [1:0] {IDLE, SCAN, LOAD} state_t;

    logic [BEAR_W-1:0]  sh_sa_q [NSLOT];
    logic [BEAR_W-1:0]  sh_ea_q [NSLOT];
    logic [RANGE_W-1:0] sh_sr_q [NSLOT];
    logic [6:0]         sh_md_q [NSLOT];
    logic [BEAR_W-1:0]  act_sa_q [NSLOT];
    logic [BEAR_W-1:0]  act_ea_q [NSLOT];
    logic [RANGE_W-1:0] act_sr_q [NSLOT];
    logic [6:0]         act_md_q [NSLOT];

    logic [BEAR_W-1:0]  bear_q, bear_prev_q;
    logic [RANGE_W-1:0] range_q, range_prev_q;
    logic [15:0]        rev_cnt_q;
    logic               commit_pend_q;
    logic               wrap, sweep, apply, wr_ok;
    logic [SW-1:0]      wr_idx;

    // A wrap is a backward bearing jump larger than half a revolution.
    assign wrap   = (bear_prev_q > bear_q) && ((bear_prev_q - bear_q) > HALF);
    assign sweep  = range_q < range_prev_q;
    assign apply  = wrap & (commit_pend_q | commit_i);
    assign wr_idx = wr_slot_i[SW-1:0];
    assign wr_ok  = wr_en_i & ~apply & ({1'b0, wr_slot_i} < 4'(NSLOT));

    assign wr_rdy_o      = ~apply;
    assign commit_pend_o = commit_pend_q;
    assign rev_cnt_o     = rev_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bear_q        <= '0;
            bear_prev_q   <= '0;
            range_q       <= '0;
            range_prev_q  <= '0;
            rev_cnt_q     <= '0;
            commit_pend_q <= 1'b0;
        end else begin
            bear_q       <= bear_i;
            bear_prev_q  <= bear_q;
            range_q      <= range_i;
            range_prev_q <= range_q;
            if (wrap) rev_cnt_q <= rev_cnt_q + 16'd1;
            if (wrap)          commit_pend_q <= 1'b0;
            else if (commit_i) commit_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                sh_sa_q[i]  <= '0; sh_ea_q[i]  <= '0; sh_sr_q[i]  <= '0; sh_md_q[i]  <= '0;
                act_sa_q[i] <= '0; act_ea_q[i] <= '0; act_sr_q[i] <= '0; act_md_q[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                case (wr_addr_i)
                    2'd0:    sh_sa_q[wr_idx] <= wr_data_i[BEAR_W-1:0];
                    2'd1:    sh_ea_q[wr_idx] <= wr_data_i[BEAR_W-1:0];
                    2'd2:    sh_sr_q[wr_idx] <= wr_data_i[RANGE_W-1:0];
                    default: sh_md_q[wr_idx] <= wr_data_i[6:0];
                endcase
            end
            if (apply) begin
                for (int i = 0; i < NSLOT; i++) begin
                    act_sa_q[i] <= sh_sa_q[i];
                    act_ea_q[i] <= sh_ea_q[i];
                    act_sr_q[i] <= sh_sr_q[i];
                    act_md_q[i] <= sh_md_q[i];
                end
            end
        end
    end

    state_t             state_q, state_d;
    logic [SW-1:0]      cnt_q, cnt_d, win_q, win_d, idx;
    logic               hit_q, hit_d, slot_hit, in_win;
    logic [BEAR_W-1:0]  sa, ea, o_sa_q, o_sa_d, o_ea_q, o_ea_d;
    logic [RANGE_W-1:0] o_sr_q, o_sr_d;
    logic [2:0]         o_am_q, o_am_d, o_rm_q, o_rm_d, o_cur_q, o_cur_d;
    logic               o_vld_q, o_vld_d;

`ifdef SIM_SCHED_RR_EN
    logic [SW-1:0] rr_q, rr_d;
    logic [SW:0]   idx_sum;
    assign idx_sum = {1'b0, rr_q} + {1'b0, cnt_q};
    assign idx     = (idx_sum >= NS) ? SW'(idx_sum - NS) : idx_sum[SW-1:0];
`else
    assign idx = cnt_q;
`endif

    // Window may straddle bearing zero when start > end.
    assign sa       = act_sa_q[idx];
    assign ea       = act_ea_q[idx];
    assign in_win   = (sa <= ea) ? (bear_q >= sa && bear_q <= ea) : (bear_q >= sa || bear_q <= ea);
    assign slot_hit = act_md_q[idx][0] & in_win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        win_d   = win_q;
        o_sa_d  = o_sa_q;
        o_ea_d  = o_ea_q;
        o_sr_d  = o_sr_q;
        o_am_d  = o_am_q;
        o_rm_d  = o_rm_q;
        o_cur_d = o_cur_q;
        o_vld_d = o_vld_q;
`ifdef SIM_SCHED_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: if (sweep) begin
                state_d = SCAN;
                cnt_d   = '0;
                hit_d   = 1'b0;
            end
            SCAN: begin
                if (!hit_q && slot_hit) begin
                    hit_d = 1'b1;
                    win_d = idx;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = LOAD;
            end
            LOAD: begin
                o_vld_d = hit_q;
                if (hit_q) begin
                    o_sa_d  = act_sa_q[win_q];
                    o_ea_d  = act_ea_q[win_q];
                    o_sr_d  = act_sr_q[win_q];
                    o_am_d  = act_md_q[win_q][3:1];
                    o_rm_d  = act_md_q[win_q][6:4];
                    o_cur_d = 3'(win_q);
`ifdef SIM_SCHED_RR_EN
                    rr_d    = (win_q == LAST) ? '0 : win_q + 1'b1;
`endif
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            win_q   <= '0;
            o_sa_q  <= '0;
            o_ea_q  <= '0;
            o_sr_q  <= '0;
            o_am_q  <= '0;
            o_rm_q  <= '0;
            o_cur_q <= '0;
            o_vld_q <= 1'b0;
`ifdef SIM_SCHED_RR_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            win_q   <= win_d;
            o_sa_q  <= o_sa_d;
            o_ea_q  <= o_ea_d;
            o_sr_q  <= o_sr_d;
            o_am_q  <= o_am_d;
            o_rm_q  <= o_rm_d;
            o_cur_q <= o_cur_d;
            o_vld_q <= o_vld_d;
`ifdef SIM_SCHED_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign start_angle_o = o_sa_q;
    assign end_angle_o   = o_ea_q;
    assign start_range_o = o_sr_q;
    assign angle_mode_o  = o_am_q;
    assign range_mode_o  = o_rm_q;
    assign slot_valid_o  = o_vld_q;
    assign cur_slot_o    = o_cur_q;
endmodule

// File: tb/tb_sim_target_sched.sv
// Scoreboard bench for sim_target_sched: a slot-level reference model predicts each grant;
// a monitor compares the DUT outputs once the grant is due.
module tb_sim_target_sched;
    localparam int NSLOT = 4;

    logic        clk, rst;
    logic        wr_en_i, wr_rdy_o, commit_i, commit_pend_o;
    logic [2:0]  wr_slot_i;
    logic [1:0]  wr_addr_i;
    logic [15:0] wr_data_i;
    logic [11:0] bear_i, start_angle_o, end_angle_o;
    logic [9:0]  range_i, start_range_o;
    logic [2:0]  angle_mode_o, range_mode_o, cur_slot_o;
    logic        slot_valid_o;
    logic [15:0] rev_cnt_o;

    sim_target_sched #(.NSLOT(NSLOT), .BEAR_W(12), .RANGE_W(10)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_rdy_o(wr_rdy_o),
        .wr_slot_i(wr_slot_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .commit_i(commit_i), .commit_pend_o(commit_pend_o), .bear_i(bear_i),
        .range_i(range_i), .start_angle_o(start_angle_o), .end_angle_o(end_angle_o),
        .start_range_o(start_range_o), .angle_mode_o(angle_mode_o),
        .range_mode_o(range_mode_o), .slot_valid_o(slot_valid_o),
        .cur_slot_o(cur_slot_o), .rev_cnt_o(rev_cnt_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int valid, slot, sa, ea, sr, am, rm, rev, pend, due;
    } exp_t;
    exp_t sb[$];

    // Reference model: banks as plain arrays, grant computed directly from the window rule.
    int m_sh[NSLOT][4];
    int m_act[NSLOT][4];
    int m_pend, m_rev, m_rr, m_bear;
    int m_valid, m_slot, m_sa, m_ea, m_sr, m_am, m_rm;

    task automatic m_reset();
        for (int s = 0; s < NSLOT; s++)
            for (int f = 0; f < 4; f++) begin m_sh[s][f] = 0; m_act[s][f] = 0; end
        m_pend = 0; m_rev = 0; m_rr = 0;
        m_valid = 0; m_slot = 0; m_sa = 0; m_ea = 0; m_sr = 0; m_am = 0; m_rm = 0;
    endtask

    task automatic m_wrap(input bit cmt);
        m_rev = (m_rev + 1) & 16'hFFFF;
        if (m_pend != 0 || cmt)
            for (int s = 0; s < NSLOT; s++)
                for (int f = 0; f < 4; f++) m_act[s][f] = m_sh[s][f];
        m_pend = 0;
    endtask

    function automatic int m_find(input int b);
        for (int k = 0; k < NSLOT; k++) begin
            int s, st, en;
            s  = (m_rr + k) % NSLOT;
            st = m_act[s][0];
            en = m_act[s][1];
            if ((m_act[s][3] & 1) == 1) begin
                if (st <= en ? (b >= st && b <= en) : (b >= st || b <= en)) return s;
            end
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int slot, input int addr, input int data);
        wr_en_i = 1; wr_slot_i = 3'(slot); wr_addr_i = 2'(addr); wr_data_i = 16'(data);
        tick();
        wr_en_i = 0;
        if (slot < NSLOT)
            m_sh[slot][addr] = (addr == 2) ? (data & 'h3FF) : (addr == 3) ? (data & 'h7F) : (data & 'hFFF);
    endtask

    task automatic setup(input int slot, input int sa, input int ea, input int sr, input int md);
        wr(slot, 0, sa); wr(slot, 1, ea); wr(slot, 2, sr); wr(slot, 3, md);
    endtask

    task automatic commit();
        commit_i = 1;
        tick();
        commit_i = 0;
        m_pend = 1;
    endtask

    task automatic set_bear(input int b);
        bear_i = 12'(b);
        if (m_bear > b && (m_bear - b) > 2048) m_wrap(0);
        m_bear = b;
        tick(); tick();
    endtask

    task automatic rev();
        set_bear(4095);
        set_bear(0);
    endtask

    task automatic sweep_start();
        range_i = 10'd500;
        tick(); tick();
        range_i = 10'd0;
    endtask

    task automatic sweep();
        exp_t e;
        int w;
        sweep_start();
        w = m_find(m_bear);
        if (w >= 0) begin
            m_valid = 1; m_slot = w;
            m_sa = m_act[w][0]; m_ea = m_act[w][1]; m_sr = m_act[w][2];
            m_am = (m_act[w][3] >> 1) & 7; m_rm = (m_act[w][3] >> 4) & 7;
`ifdef SIM_SCHED_RR_EN
            m_rr = (w + 1) % NSLOT;
`endif
        end else m_valid = 0;
        e.valid = m_valid; e.slot = m_slot; e.sa = m_sa; e.ea = m_ea; e.sr = m_sr;
        e.am = m_am; e.rm = m_rm; e.rev = m_rev; e.pend = m_pend; e.due = cyc + NSLOT + 4;
        sb.push_back(e);
        repeat (NSLOT + 7) tick();
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && cyc >= sb[0].due) begin
            exp_t e;
            e = sb.pop_front();
            chk("slot_valid", 32'(slot_valid_o), 32'(e.valid));
            chk("cur_slot", 32'(cur_slot_o), 32'(e.slot));
            chk("start_angle", 32'(start_angle_o), 32'(e.sa));
            chk("end_angle", 32'(end_angle_o), 32'(e.ea));
            chk("start_range", 32'(start_range_o), 32'(e.sr));
            chk("angle_mode", 32'(angle_mode_o), 32'(e.am));
            chk("range_mode", 32'(range_mode_o), 32'(e.rm));
            chk("rev_cnt", 32'(rev_cnt_o), 32'(e.rev));
            chk("commit_pend", 32'(commit_pend_o), 32'(e.pend));
        end
    end

    initial begin
        int rev0;
        rst = 1; wr_en_i = 0; wr_slot_i = 0; wr_addr_i = 0; wr_data_i = 0;
        commit_i = 0; bear_i = 0; range_i = 0; m_bear = 0;
        m_reset();
        repeat (2) tick();
        rst = 0;
        tick();
        chk("rst_slot_valid", 32'(slot_valid_o), 0);
        chk("rst_wr_rdy", 32'(wr_rdy_o), 1);
        chk("rst_commit_pend", 32'(commit_pend_o), 0);
        chk("rst_rev_cnt", 32'(rev_cnt_o), 0);

        // Commit waits for the revolution wrap.
        setup(0, 100, 200, 50, 'h01);
        commit();
        chk("pend_after_commit", 32'(commit_pend_o), 1);
        set_bear(2000);
        chk("pend_hold_2000", 32'(commit_pend_o), 1);
        set_bear(4095);
        chk("pend_hold_4095", 32'(commit_pend_o), 1);
        set_bear(0);
        chk("pend_clear_wrap", 32'(commit_pend_o), 0);
        chk("rev_after_wrap", 32'(rev_cnt_o), 1);
        set_bear(150);
        sweep();

        // Reset in the middle of a scan.
        sweep_start();
        repeat (3) tick();
        rst = 1;
        #1;
        chk("midrst_slot_valid", 32'(slot_valid_o), 0);
        chk("midrst_start_angle", 32'(start_angle_o), 0);
        chk("midrst_end_angle", 32'(end_angle_o), 0);
        chk("midrst_cur_slot", 32'(cur_slot_o), 0);
        chk("midrst_wr_rdy", 32'(wr_rdy_o), 1);
        chk("midrst_rev_cnt", 32'(rev_cnt_o), 0);
        m_reset();
        tick();
        rst = 0;
        repeat (NSLOT + 4) tick();
        chk("post_rst_idle_valid", 32'(slot_valid_o), 0);

        // Wrapping window on slot1.
        setup(0, 100, 200, 50, 'h01);
        setup(1, 4000, 50, 75, 'h35);
        commit();
        rev();
        set_bear(4050); sweep();
        set_bear(20);   sweep();
        set_bear(60);   sweep();

        // Shadow writes stay invisible without a commit.
        wr(0, 1, 120);
        rev0 = m_rev;
        rev(); rev(); rev();
        chk("rev_plus3", 32'(rev_cnt_o), 32'((rev0 + 3) & 'hFFFF));
        set_bear(150); sweep();

        // Overlapping windows.
        setup(0, 250, 350, 10, 'h03);
        setup(2, 280, 320, 20, 'h51);
        commit();
        rev();
        set_bear(300);
        sweep(); sweep(); sweep();

        // Out-of-range slot writes are dropped.
        setup(5, 0, 0, 0, 0);
        commit();
        rev();
        set_bear(20); sweep();

        // Commit on the wrap clock takes effect at once.
        wr(1, 3, 0);
        set_bear(4095);
        bear_i = 12'd0;
        @(posedge clk);
        @(negedge clk);
        commit_i = 1;
        #1;
        chk("wrap_commit_wr_rdy", 32'(wr_rdy_o), 0);
        chk("wrap_commit_no_pend", 32'(commit_pend_o), 0);
        tick();
        commit_i = 0;
        m_wrap(1);
        m_bear = 0;
        chk("wrap_commit_pend_after", 32'(commit_pend_o), 0);
        chk("wrap_commit_wr_rdy_after", 32'(wr_rdy_o), 1);
        set_bear(20); sweep();

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 2; k++) begin
                int a;
                a = $urandom_range(0, 3);
                wr($urandom_range(0, 7), a, (a == 3) ? $urandom_range(0, 127) : $urandom_range(0, 4095));
            end
            if ($urandom_range(0, 1) == 1) commit();
            if ($urandom_range(0, 1) == 1) rev();
            set_bear($urandom_range(0, 4095));
            sweep();
        end

        repeat (NSLOT + 8) tick();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
